// File: rtl/stream_s2mm_writer.sv
// stream_s2mm_writer
// Receive-side stream sink: accepts valid/ready beats and writes each one to a
// single-port RAM at base_addr + beat index. It counts beats per frame, checks
// tlast against the programmed frame length, and reports done and sticky errors.
// A single output register (valid/address/data) sits between the stream and the
// RAM port, so the input can take one beat per cycle while mem_wready stays high.

module stream_s2mm_writer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 20,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    // control
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [CNT_W-1:0]  i_frame_beats,
    // input stream
    input  logic              i_s_tvalid,
    output logic              o_s_tready,
    input  logic [DATA_W-1:0] i_s_tdata,
    input  logic              i_s_tlast,
    // RAM write port
    output logic              o_mem_we,
    input  logic              i_mem_wready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    // status
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_beat_cnt,
    output logic              o_err_early_last,
    output logic              o_err_no_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // frame parameters captured at start
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_len;

    // output register feeding the RAM port
    logic              r_vld;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // frame progress and sticky errors
    logic [CNT_W-1:0]  r_beat_cnt;
    logic              r_err_early_last;
    logic              r_err_no_last;

    logic              w_s_tready;
    logic              w_accept;
    logic              w_wr_done;
    logic              w_start_ok;
    logic [CNT_W-1:0]  w_last_idx;
    logic              w_at_last;
    logic              w_final_beat;
    logic [ADDR_W-1:0] w_beat_addr;

    // The register may take a new beat when it is empty or being drained this cycle.
    assign w_s_tready   = (r_state == S_RUN) && (!r_vld || i_mem_wready);
    assign w_accept     = i_s_tvalid && w_s_tready;
    assign w_wr_done    = r_vld && i_mem_wready;
    assign w_start_ok   = (r_state == S_IDLE) && i_start;
    // r_len is never zero while in RUN, so len-1 cannot underflow when it matters
    assign w_last_idx   = r_len - CNT_W'(1);
    assign w_at_last    = (r_beat_cnt == w_last_idx);
    assign w_final_beat = w_at_last || i_s_tlast;
    // low beat-count bits are enough: the address wraps modulo 2^ADDR_W anyway
    assign w_beat_addr  = r_base + r_beat_cnt[ADDR_W-1:0];

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = (i_frame_beats != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (w_accept && w_final_beat) begin
                    w_state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_wr_done) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // state-decoded outputs
    always_comb begin
        o_s_tready = w_s_tready;
        o_busy     = (r_state == S_RUN) || (r_state == S_FLUSH);
        o_done     = (r_state == S_DONE);
    end

    // frame parameters, beat counter and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base           <= '0;
            r_len            <= '0;
            r_beat_cnt       <= '0;
            r_err_early_last <= 1'b0;
            r_err_no_last    <= 1'b0;
        end else if (w_start_ok) begin
            r_base           <= i_base_addr;
            r_len            <= i_frame_beats;
            r_beat_cnt       <= '0;
            r_err_early_last <= 1'b0;
            r_err_no_last    <= 1'b0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (i_s_tlast && !w_at_last) begin
                r_err_early_last <= 1'b1;
            end
            if (w_at_last && !i_s_tlast) begin
                r_err_no_last <= 1'b1;
            end
        end
    end

    // output register: reload on accept, drain on completed write, hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_vld  <= 1'b1;
            r_addr <= w_beat_addr;
            r_data <= i_s_tdata;
        end else if (w_wr_done) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_mem_we         = r_vld;
    assign o_mem_addr       = r_addr;
    assign o_mem_wdata      = r_data;
    assign o_beat_cnt       = r_beat_cnt;
    assign o_err_early_last = r_err_early_last;
    assign o_err_no_last    = r_err_no_last;

endmodule

// File: tb/tb_stream_s2mm_writer.sv
// tb_stream_s2mm_writer
// Scoreboard bench: the stimulus pushes the expected RAM write (address, data,
// frame-final flag) for every beat it expects to be accepted; an independent
// monitor pops and compares on each completed write and checks the handshake
// rules (register hold on stall, tready low on stall, done timing).

module tb_stream_s2mm_writer;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 20;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [ADDR_W-1:0] i_base_addr;
    logic [CNT_W-1:0]  i_frame_beats;
    logic              i_s_tvalid;
    logic              o_s_tready;
    logic [DATA_W-1:0] i_s_tdata;
    logic              i_s_tlast;
    logic              o_mem_we;
    logic              i_mem_wready;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic              o_busy;
    logic              o_done;
    logic [CNT_W-1:0]  o_beat_cnt;
    logic              o_err_early_last;
    logic              o_err_no_last;

    stream_s2mm_writer #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_base_addr     (i_base_addr),
        .i_frame_beats   (i_frame_beats),
        .i_s_tvalid      (i_s_tvalid),
        .o_s_tready      (o_s_tready),
        .i_s_tdata       (i_s_tdata),
        .i_s_tlast       (i_s_tlast),
        .o_mem_we        (o_mem_we),
        .i_mem_wready    (i_mem_wready),
        .o_mem_addr      (o_mem_addr),
        .o_mem_wdata     (o_mem_wdata),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_beat_cnt      (o_beat_cnt),
        .o_err_early_last(o_err_early_last),
        .o_err_no_last   (o_err_no_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                is_last;
    } wr_t;

    wr_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int wr_mode  = 0;   // 0: wready=1, 1: toggle, 2: wready=0, 3: driven by stimulus

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int t, input int i);
        return {16'hCAFE, 16'(t), 32'h1000_0000 + 32'(i)};
    endfunction

    // RAM-side backpressure pattern
    always @(posedge clk) begin
        #1;
        case (wr_mode)
            0: i_mem_wready = 1'b1;
            1: i_mem_wready = ~i_mem_wready;
            2: i_mem_wready = 1'b0;
            default: ;
        endcase
    end

    // monitor: scoreboard compare and handshake rules, sampled on the falling edge
    bit                m_prev_acc   = 0;
    bit                m_prev_stall = 0;
    bit                m_prev_done  = 0;
    bit                m_exp_done   = 0;
    logic [ADDR_W-1:0] m_prev_addr;
    logic [DATA_W-1:0] m_prev_data;
    always @(negedge clk) begin
        if (rst) begin
            m_prev_acc   = 0;
            m_prev_stall = 0;
            m_prev_done  = 0;
            m_exp_done   = 0;
        end else begin
            if (m_prev_acc) check("we_after_accept", o_mem_we, 1);
            if (m_prev_stall) begin
                check("we_hold_on_stall", o_mem_we, 1);
                check("addr_hold_on_stall", o_mem_addr, m_prev_addr);
                check("data_hold_on_stall", o_mem_wdata, m_prev_data);
            end
            if (m_exp_done) begin
                check("done_after_last_write", o_done, 1);
                m_exp_done = 0;
            end
            if (o_done) begin
                check("done_single_cycle", m_prev_done, 0);
                done_cnt++;
            end
            if (o_mem_we && !i_mem_wready) check("tready_low_on_stall", o_s_tready, 0);
            if (o_mem_we && i_mem_wready) begin
                $display("write addr=0x%05h data=0x%016h", o_mem_addr, o_mem_wdata);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", o_mem_addr, e.addr);
                    check("wr_data", o_mem_wdata, e.data);
                    if (e.is_last) m_exp_done = 1;
                end
            end
            m_prev_acc   = i_s_tvalid && o_s_tready;
            m_prev_stall = o_mem_we && !i_mem_wready;
            m_prev_addr  = o_mem_addr;
            m_prev_data  = o_mem_wdata;
            m_prev_done  = o_done;
        end
    end

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] len);
        @(posedge clk); #1;
        i_start = 1'b1; i_base_addr = base; i_frame_beats = len;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // start a frame and offer n_acc beats, each pushed to the scoreboard before offering
    task automatic send_frame(input int t, input logic [ADDR_W-1:0] base,
                              input logic [CNT_W-1:0] len, input int n_acc,
                              input int last_at, input bit rnd, input int start_at,
                              input bit mark_last);
        pulse_start(base, len);
        for (int i = 0; i < n_acc; i++) begin
            bit acc;
            int cyc;
            wr_t e;
            e.addr    = base + ADDR_W'(i);
            e.data    = pat(t, i);
            e.is_last = mark_last && (i == n_acc - 1);
            exp_q.push_back(e);
            acc = 0;
            cyc = 0;
            while (!acc && cyc < 200) begin
                i_s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                i_s_tdata  = pat(t, i);
                i_s_tlast  = (i == last_at);
                if (i == start_at && cyc == 0) begin
                    i_start = 1'b1; i_base_addr = 20'h12345; i_frame_beats = 3;
                end
                @(negedge clk);
                acc = i_s_tvalid && o_s_tready;
                @(posedge clk); #1;
                i_start = 1'b0;
                cyc++;
            end
            if (!acc) check("beat_accept_timeout", 0, 1);
        end
        i_s_tvalid = 1'b0;
        i_s_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int cyc = 0;
        while (done_cnt < target && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        check("done_seen", (done_cnt >= target), 1);
        @(posedge clk); #1;
    endtask

    task automatic check_status(input string tag, input logic [CNT_W-1:0] cnt,
                                input logic early, input logic nolast);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_beat_cnt"}, o_beat_cnt, cnt);
        check({tag, "_err_early_last"}, o_err_early_last, early);
        check({tag, "_err_no_last"}, o_err_no_last, nolast);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tready"}, o_s_tready, 0);
        check({tag, "_mem_we"}, o_mem_we, 0);
        check({tag, "_mem_addr"}, o_mem_addr, 0);
        check({tag, "_mem_wdata"}, o_mem_wdata, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_beat_cnt"}, o_beat_cnt, 0);
        check({tag, "_err_early"}, o_err_early_last, 0);
        check({tag, "_err_no_last"}, o_err_no_last, 0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; i_start = 1'b0; i_base_addr = '0; i_frame_beats = '0;
        i_s_tvalid = 1'b0; i_s_tdata = '0; i_s_tlast = 1'b0; i_mem_wready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // T1: base 0, 8 beats, tlast on beat 7, full throughput
        wr_mode = 0;
        send_frame(1, 20'h00000, 8, 8, 7, 0, -1, 1);
        wait_done(1);
        check_status("t1", 8, 0, 0);

        // T2: 16 beats, wready toggling, random tvalid, a start mid-frame is ignored
        wr_mode = 1;
        send_frame(2, 20'h00100, 16, 16, 15, 1, 7, 1);
        wait_done(2);
        check_status("t2", 16, 0, 0);
        wr_mode = 0;

        // T3: 10-beat frame with tlast on beat 5; later beats are refused
        send_frame(3, 20'h00200, 10, 6, 5, 0, -1, 1);
        i_s_tvalid = 1'b1; i_s_tdata = pat(3, 6);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_tready_after_end", o_s_tready, 0);
        end
        i_s_tvalid = 1'b0;
        wait_done(3);
        check_status("t3", 6, 1, 0);

        // T4: 4 beats without tlast
        send_frame(4, 20'h00300, 4, 4, -1, 0, -1, 1);
        wait_done(4);
        check_status("t4", 4, 0, 1);

        // zero-length frame: straight to done, no writes, errors cleared
        pulse_start(20'h00400, 0);
        wait_done(5);
        check_status("len0", 0, 0, 0);

        // T5: address wrap at the top of the RAM
        send_frame(5, 20'hFFFFE, 4, 4, 3, 0, -1, 1);
        wait_done(6);
        check_status("t5", 4, 0, 0);

        // T6: reset with beat 3 of 8 pending and wready low
        send_frame(6, 20'h00040, 8, 3, -1, 0, -1, 0);
        wr_mode = 3;
        i_mem_wready = 1'b1;
        i_s_tvalid = 1'b1; i_s_tdata = pat(6, 3); i_s_tlast = 1'b0;
        @(negedge clk);
        check("t6_beat3_ready", o_s_tready, 1);
        @(posedge clk); #1;
        i_s_tvalid = 1'b0; i_mem_wready = 1'b0;
        @(negedge clk);
        check("t6_write_pending", o_mem_we, 1);
        d0 = done_cnt;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("t6_after_rst");
        rst = 1'b0; i_mem_wready = 1'b1; wr_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_done", done_cnt, d0);
        check("t6_queue_drained", exp_q.size(), 0);
        send_frame(7, 20'h00010, 2, 2, 1, 0, -1, 1);
        wait_done(d0 + 1);
        check_status("t6_restart", 2, 0, 0);

        repeat (4) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

endmodule
